// File: rtl/seq_gen_pkg.sv
// rtl/seq_gen_pkg.sv - mode encodings and start/gray helpers for the multi-mode sequence generator
package seq_gen_pkg;

  localparam logic [1:0] MODE_BIN  = 2'd0;
  localparam logic [1:0] MODE_GRAY = 2'd1;
  localparam logic [1:0] MODE_JOHN = 2'd2;
  localparam logic [1:0] MODE_LFSR = 2'd3;

  // Helpers work on a 64-bit word; callers size-cast to their own WIDTH.
  function automatic logic [63:0] start_val(input logic [1:0] mode, input logic [63:0] seed);
    if (mode == MODE_LFSR) return (seed == 64'd0) ? 64'd1 : seed;
    return 64'd0;
  endfunction

  function automatic logic [63:0] bin2gray(input logic [63:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/seq_gen_next.sv
// rtl/seq_gen_next.sv - combinational next-state equations for all four sequence modes
module seq_gen_next
  import seq_gen_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
  input  logic [WIDTH-1:0] st,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = st + WIDTH'(1);
    case (mode)
      MODE_JOHN: nxt = {st[WIDTH-2:0], ~st[WIDTH-1]};
      MODE_LFSR: nxt = {st[WIDTH-2:0], ^(st & TAPS)};
      default:   nxt = st + WIDTH'(1);
    endcase
  end

endmodule

// File: rtl/seq_gen_multi.sv
// rtl/seq_gen_multi.sv - multi-mode sequence generator: binary, Gray, Johnson and LFSR with load and wrap pulse
module seq_gen_multi
  import seq_gen_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] seq_out,
  output logic             serial_out,
  output logic             wrap
);

  logic [WIDTH-1:0] st;
  logic [1:0]       cur_mode;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] start_mode;

  seq_gen_next #(
    .WIDTH(WIDTH),
    .TAPS (TAPS)
  ) u_next (
    .st  (st),
    .mode(cur_mode),
    .nxt (nxt)
  );

  // The en branch is only reached when mode == cur_mode, so one start value serves all branches.
  assign start_mode = WIDTH'(start_val(mode, 64'(SEED)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= '0;
      cur_mode <= MODE_BIN;
      wrap     <= 1'b0;
    end else if (load) begin
      cur_mode <= mode;
      st       <= (mode == MODE_LFSR && load_val == '0) ? start_mode : load_val;
      wrap     <= 1'b0;
    end else if (mode != cur_mode) begin
      cur_mode <= mode;
      st       <= start_mode;
      wrap     <= 1'b0;
    end else if (en) begin
      st       <= nxt;
      wrap     <= (nxt == start_mode);
    end else begin
      wrap     <= 1'b0;
    end
  end

  assign seq_out    = (cur_mode == MODE_GRAY) ? WIDTH'(bin2gray(64'(st))) : st;
  assign serial_out = st[WIDTH-1];

endmodule

// File: tb/tb_seq_gen_multi.sv
// tb/tb_seq_gen_multi.sv - directed self-checking bench for seq_gen_multi at WIDTH=8
module tb_seq_gen_multi;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] seq_out;
  logic       serial_out;
  logic       wrap;

  int checks;
  int failures;

  seq_gen_multi #(
    .WIDTH(8),
    .TAPS (8'hB8),
    .SEED (8'h01)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .load      (load),
    .load_val  (load_val),
    .seq_out   (seq_out),
    .serial_out(serial_out),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; en = 1'b0; mode = 2'd0; load = 1'b0; load_val = 8'h00;
    #12;
    checks++;
    if (seq_out !== 8'h00) begin failures++; $display("FAIL reset_seq got=%h exp=00", seq_out); end
    checks++;
    if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    checks++;
    if (serial_out !== 1'b0) begin failures++; $display("FAIL reset_serial got=%b exp=0", serial_out); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++;
    if (seq_out !== 8'h00) begin failures++; $display("FAIL reset_hold got=%h exp=00", seq_out); end
  endtask

  task automatic test_bin;
    logic [8:0] i9;
    en = 1'b1; mode = 2'd0;
    for (int i = 1; i <= 256; i++) begin
      tick();
      i9 = 9'(i);
      checks++;
      if (seq_out !== i9[7:0]) begin failures++; $display("FAIL bin_seq step=%0d got=%h exp=%h", i, seq_out, i9[7:0]); end
      checks++;
      if (wrap !== (i == 256)) begin failures++; $display("FAIL bin_wrap step=%0d got=%b exp=%b", i, wrap, (i == 256)); end
    end
    en = 1'b0;
  endtask

  task automatic test_gray;
    logic [7:0] prev;
    logic [7:0] b;
    logic [7:0] exp_first [8] = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04};
    en = 1'b0; mode = 2'd1;
    tick();
    checks++;
    if (seq_out !== 8'h00) begin failures++; $display("FAIL gray_start got=%h exp=00", seq_out); end
    prev = seq_out;
    en = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      b = 8'(i);
      if (i < 8) begin
        checks++;
        if (seq_out !== exp_first[i]) begin failures++; $display("FAIL gray_table step=%0d got=%h exp=%h", i, seq_out, exp_first[i]); end
      end
      checks++;
      if (seq_out !== (b ^ (b >> 1))) begin failures++; $display("FAIL gray_seq step=%0d got=%h exp=%h", i, seq_out, b ^ (b >> 1)); end
      checks++;
      if ($countones(seq_out ^ prev) != 1) begin failures++; $display("FAIL gray_onebit step=%0d got=%h prev=%h exp_dist=1", i, seq_out, prev); end
      checks++;
      if (wrap !== (i == 256)) begin failures++; $display("FAIL gray_wrap step=%0d got=%b exp=%b", i, wrap, (i == 256)); end
      prev = seq_out;
    end
    en = 1'b0;
  endtask

  task automatic test_john;
    logic [7:0] exp_tab [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    logic [7:0] e;
    en = 1'b0; mode = 2'd2;
    tick();
    checks++;
    if (seq_out !== 8'h00) begin failures++; $display("FAIL john_start got=%h exp=00", seq_out); end
    en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      e = exp_tab[i-1];
      checks++;
      if (seq_out !== e) begin failures++; $display("FAIL john_seq step=%0d got=%h exp=%h", i, seq_out, e); end
      checks++;
      if (serial_out !== e[7]) begin failures++; $display("FAIL john_serial step=%0d got=%b exp=%b", i, serial_out, e[7]); end
      checks++;
      if (wrap !== (i == 16)) begin failures++; $display("FAIL john_wrap step=%0d got=%b exp=%b", i, wrap, (i == 16)); end
    end
    en = 1'b0;
  endtask

  task automatic test_lfsr;
    logic [7:0] exp_first [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    en = 1'b0; mode = 2'd3;
    tick();
    checks++;
    if (seq_out !== 8'h01) begin failures++; $display("FAIL lfsr_start got=%h exp=01", seq_out); end
    en = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (i < 5) begin
        checks++;
        if (seq_out !== exp_first[i]) begin failures++; $display("FAIL lfsr_table step=%0d got=%h exp=%h", i, seq_out, exp_first[i]); end
      end
      checks++;
      if (seq_out === 8'h00) begin failures++; $display("FAIL lfsr_zero step=%0d got=%h exp=nonzero", i, seq_out); end
      checks++;
      if ((seq_out === 8'h01) !== (i == 255)) begin failures++; $display("FAIL lfsr_period step=%0d got=%h exp_is_start=%b", i, seq_out, (i == 255)); end
      checks++;
      if (wrap !== (i == 255)) begin failures++; $display("FAIL lfsr_wrap step=%0d got=%b exp=%b", i, wrap, (i == 255)); end
    end
    en = 1'b0;
  endtask

  task automatic test_load;
    en = 1'b1; mode = 2'd3;
    tick(); tick();
    checks++;
    if (seq_out !== 8'h04) begin failures++; $display("FAIL load_lfsr_pre got=%h exp=04", seq_out); end
    en = 1'b0; load = 1'b1; load_val = 8'h00;
    tick();
    checks++;
    if (seq_out !== 8'h01) begin failures++; $display("FAIL load_lfsr_zero got=%h exp=01", seq_out); end
    mode = 2'd0; load_val = 8'hFE;
    tick();
    checks++;
    if (seq_out !== 8'hFE || wrap !== 1'b0) begin failures++; $display("FAIL load_bin_fe got=%h/%b exp=fe/0", seq_out, wrap); end
    load = 1'b0; en = 1'b1;
    tick();
    checks++;
    if (seq_out !== 8'hFF || wrap !== 1'b0) begin failures++; $display("FAIL load_bin_ff got=%h/%b exp=ff/0", seq_out, wrap); end
    tick();
    checks++;
    if (seq_out !== 8'h00 || wrap !== 1'b1) begin failures++; $display("FAIL load_bin_wrap got=%h/%b exp=00/1", seq_out, wrap); end
    en = 1'b0;
    tick();
    checks++;
    if (seq_out !== 8'h00 || wrap !== 1'b0) begin failures++; $display("FAIL load_bin_hold got=%h/%b exp=00/0", seq_out, wrap); end
    mode = 2'd2; load = 1'b1; load_val = 8'h5A;
    tick();
    checks++;
    if (seq_out !== 8'h5A) begin failures++; $display("FAIL load_wins got=%h exp=5a", seq_out); end
    load = 1'b0;
    tick();
    checks++;
    if (seq_out !== 8'h5A) begin failures++; $display("FAIL load_wins_hold got=%h exp=5a", seq_out); end
    mode = 2'd1; load = 1'b1; load_val = 8'h05;
    tick();
    load = 1'b0;
    checks++;
    if (seq_out !== 8'h07) begin failures++; $display("FAIL load_gray got=%h exp=07", seq_out); end
  endtask

  task automatic test_mode_change;
    en = 1'b0; mode = 2'd0; load = 1'b1; load_val = 8'h37;
    tick();
    load = 1'b0;
    checks++;
    if (seq_out !== 8'h37) begin failures++; $display("FAIL mode_pre got=%h exp=37", seq_out); end
    mode = 2'd3;
    tick();
    checks++;
    if (seq_out !== 8'h01 || wrap !== 1'b0) begin failures++; $display("FAIL mode_to_lfsr got=%h/%b exp=01/0", seq_out, wrap); end
    mode = 2'd0; load = 1'b1; load_val = 8'h37;
    tick();
    load = 1'b0; en = 1'b1; mode = 2'd2;
    tick();
    checks++;
    if (seq_out !== 8'h00 || wrap !== 1'b0) begin failures++; $display("FAIL mode_to_john_en got=%h/%b exp=00/0", seq_out, wrap); end
    tick();
    checks++;
    if (seq_out !== 8'h01) begin failures++; $display("FAIL mode_john_run got=%h exp=01", seq_out); end
    en = 1'b0;
  endtask

  task automatic test_async_reset;
    mode = 2'd0; load = 1'b1; load_val = 8'hFF; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    checks++;
    if (wrap !== 1'b1) begin failures++; $display("FAIL areset_pre_wrap got=%b exp=1", wrap); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (wrap !== 1'b0 || seq_out !== 8'h00) begin failures++; $display("FAIL areset_wrap got=%h/%b exp=00/0", seq_out, wrap); end
    #2 reset = 1'b1;
    en = 1'b0; mode = 2'd1; load = 1'b1; load_val = 8'hC3;
    tick();
    load = 1'b0;
    checks++;
    if (seq_out !== 8'hA2) begin failures++; $display("FAIL areset_pre_val got=%h exp=a2", seq_out); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (seq_out !== 8'h00 || serial_out !== 1'b0) begin failures++; $display("FAIL areset_mid got=%h/%b exp=00/0", seq_out, serial_out); end
    mode = 2'd0; en = 1'b1;
    #2 reset = 1'b1;
    tick();
    checks++;
    if (seq_out !== 8'h01) begin failures++; $display("FAIL areset_restart1 got=%h exp=01", seq_out); end
    tick();
    checks++;
    if (seq_out !== 8'h02) begin failures++; $display("FAIL areset_restart2 got=%h exp=02", seq_out); end
    en = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_bin();
    test_gray();
    test_john();
    test_lfsr();
    test_load();
    test_mode_change();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
